// File: rtl/alu_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_divider_pkg
// Purpose  : Shared widths, flag indices, divider state encoding and a small
//            conditional-negate helper for the iterative divider.
// Revision : 1.0 - initial release
// ============================================================================
package alu_divider_pkg;

  localparam int CPU_WORD_WIDTH    = 32;
  localparam int CPU_FLAGS_MSB_POS = 3;
  localparam int DIV_COUNT_WIDTH   = $clog2(CPU_WORD_WIDTH);

  // Flag bit positions inside the flags word.
  localparam int FlagN = 3;
  localparam int FlagZ = 2;
  localparam int FlagC = 1;
  localparam int FlagV = 0;

  typedef enum logic [1:0] {
    DivIdle = 2'd0,
    DivIter = 2'd1,
    DivFix  = 2'd2,
    DivDone = 2'd3
  } DivState;

  // Two's-complement negate when neg is set; used both for operand magnitude
  // and for restoring result signs.
  function automatic logic [CPU_WORD_WIDTH-1:0] cond_neg(
    input logic [CPU_WORD_WIDTH-1:0] v,
    input logic                      neg
  );
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module   : alu_divider_div_step
// Purpose  : One radix-2 restoring step: shift {rem, dividend} left by one and
//            trial-subtract the divisor, producing the next partial remainder,
//            the shifted dividend with the new quotient bit in its LSB.
// Revision : 1.0 - initial release
// ============================================================================
module alu_divider_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] dividend_i,
  input  logic [W-1:0] divisor_i,
  output logic [W-1:0] rem_o,
  output logic [W-1:0] dividend_o,
  output logic         qbit_o
);

  // The shifted partial remainder needs one extra bit because it can reach
  // 2*divisor-1; when the subtraction succeeds the result fits back into W.
  logic [W:0]   cand;
  logic [W-1:0] diff;

  assign cand       = {rem_i, dividend_i[W-1]};
  assign diff       = cand[W-1:0] - divisor_i;
  assign qbit_o     = (cand >= {1'b0, divisor_i});
  assign rem_o      = qbit_o ? diff : cand[W-1:0];
  assign dividend_o = {dividend_i[W-2:0], qbit_o};

endmodule
`default_nettype wire

// File: rtl/alu_divider.sv
`default_nettype none
// ============================================================================
// Module   : alu_divider
// Purpose  : Iterative 32-bit signed/unsigned divider with valid/ready
//            handshakes. Operates on magnitudes, one quotient bit per cycle,
//            then restores signs. Produces quotient, remainder and N/Z/V/C.
// Revision : 1.0 - initial release
// ============================================================================
module alu_divider
  import alu_divider_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CPU_WORD_WIDTH-1:0]    a_in,
  input  logic [CPU_WORD_WIDTH-1:0]    b_in,
  input  logic                         is_signed,
  input  logic [CPU_FLAGS_MSB_POS:0]   flags_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CPU_WORD_WIDTH-1:0]    quot,
  output logic [CPU_WORD_WIDTH-1:0]    rem,
  output logic [CPU_FLAGS_MSB_POS:0]   flags_out
);

  localparam int W = CPU_WORD_WIDTH;
  localparam logic [DIV_COUNT_WIDTH-1:0] LAST_COUNT = DIV_COUNT_WIDTH'(W - 1);
  localparam logic [W-1:0] MIN_INT = {1'b1, {(W-1){1'b0}}};

  DivState                    state_q;
  logic [DIV_COUNT_WIDTH-1:0] count_q;
  logic [W-1:0]               rem_q;
  logic [W-1:0]               dvd_q;
  logic [W-1:0]               div_q;
  logic                       qneg_q;
  logic                       rneg_q;
  logic                       carry_q;
  logic                       ovf_q;
  logic                       out_valid_q;
  logic [W-1:0]               quot_q;
  logic [W-1:0]               rem_out_q;
  logic [CPU_FLAGS_MSB_POS:0] flags_q;

  logic [W-1:0]               rem_d;
  logic [W-1:0]               dvd_d;
  logic                       qbit_d;

  logic                       sa;
  logic                       sb;
  logic                       div_by_zero;
  logic                       signed_ovf;
  logic [W-1:0]               quot_fix;
  logic [W-1:0]               rem_fix;
  logic [CPU_FLAGS_MSB_POS:0] flags_fix;
  logic                       unused_flags;

  // Only the carry is passed through; the other incoming flags are recomputed.
  assign unused_flags = ^{flags_in[FlagN], flags_in[FlagZ], flags_in[FlagV], qbit_d};

  assign sa          = is_signed & a_in[W-1];
  assign sb          = is_signed & b_in[W-1];
  assign div_by_zero = (b_in == '0);
  assign signed_ovf  = is_signed && (a_in == MIN_INT) && (b_in == '1);

  assign quot_fix = cond_neg(dvd_q, qneg_q);
  assign rem_fix  = cond_neg(rem_q, rneg_q);

  // Result flags are derived from the sign-corrected quotient.
  always_comb begin
    flags_fix        = '0;
    flags_fix[FlagN] = quot_fix[W-1];
    flags_fix[FlagZ] = (quot_fix == '0);
    flags_fix[FlagV] = ovf_q;
    flags_fix[FlagC] = carry_q;
  end

  alu_divider_div_step #(.W(W)) u_step (
    .rem_i      (rem_q),
    .dividend_i (dvd_q),
    .divisor_i  (div_q),
    .rem_o      (rem_d),
    .dividend_o (dvd_d),
    .qbit_o     (qbit_d)
  );

  // Divider sequencer: accept, iterate, fix signs, hold result until taken.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= DivIdle;
      count_q     <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      div_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      quot_q      <= '0;
      rem_out_q   <= '0;
      flags_q     <= '0;
    end else begin
      case (state_q)
        DivIdle: begin
          if (in_valid) begin
            carry_q <= flags_in[FlagC];
            count_q <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            // Special cases preload their final values and skip iteration;
            // they still pass through DivFix so both paths share the result
            // registers, giving a one-edge accept-to-valid latency.
            if (div_by_zero) begin
              dvd_q   <= '1;
              rem_q   <= a_in;
              ovf_q   <= 1'b1;
              state_q <= DivFix;
            end else if (signed_ovf) begin
              dvd_q   <= MIN_INT;
              rem_q   <= '0;
              ovf_q   <= 1'b1;
              state_q <= DivFix;
            end else begin
              dvd_q   <= cond_neg(a_in, sa);
              div_q   <= cond_neg(b_in, sb);
              rem_q   <= '0;
              qneg_q  <= sa ^ sb;
              rneg_q  <= sa;
              ovf_q   <= 1'b0;
              state_q <= DivIter;
            end
          end
        end
        DivIter: begin
          rem_q   <= rem_d;
          dvd_q   <= dvd_d;
          count_q <= count_q + 1'b1;
          if (count_q == LAST_COUNT) begin
            state_q <= DivFix;
          end
        end
        DivFix: begin
          quot_q      <= quot_fix;
          rem_out_q   <= rem_fix;
          flags_q     <= flags_fix;
          out_valid_q <= 1'b1;
          state_q     <= DivDone;
        end
        DivDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= DivIdle;
          end
        end
        default: state_q <= DivIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == DivIdle);
  assign out_valid = out_valid_q;
  assign quot      = quot_q;
  assign rem       = rem_out_q;
  assign flags_out = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_divider
// Purpose  : Self-checking bench for alu_divider: directed corner cases,
//            backpressure, mid-operation reset and randomized operands
//            compared against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_divider;
  import alu_divider_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic        is_signed = 1'b0;
  logic [3:0]  flags_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [3:0]  flags_out;

  int n_cmp = 0;
  int n_bad = 0;

  alu_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .is_signed (is_signed),
    .flags_in  (flags_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .flags_out (flags_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic; SV division truncates toward zero
  // and the remainder takes the dividend's sign.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input logic s, input logic [3:0] f,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic [3:0] fl);
    longint sa;
    longint sb;
    logic   v;
    v = 1'b0;
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a; v = 1'b1;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'h0; v = 1'b1;
    end else if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
    fl = '0;
    fl[FlagN] = q[31];
    fl[FlagZ] = (q == 0);
    fl[FlagV] = v;
    fl[FlagC] = f[FlagC];
  endfunction

  // Called #1 after the accept edge: waits for out_valid, checks it, then
  // completes the result handshake.
  task automatic wait_result(input string tag, input logic [31:0] eq, input logic [31:0] er,
                             input logic [3:0] ef, input int exp_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " quot"}, quot, eq);
    chk({tag, " rem"}, rem, er);
    chk({tag, " flags"}, 32'(flags_out), 32'(ef));
    if (!out_ready) begin
      @(negedge clk); out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " handshake valid"}, 32'(out_valid), 32'd0);
    chk({tag, " handshake ready"}, 32'(in_ready), 32'd1);
  endtask

  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [3:0] f, input logic early);
    logic [31:0] eq;
    logic [31:0] er;
    logic [3:0]  ef;
    int          t;
    ref_div(a, b, s, f, eq, er, ef);
    @(negedge clk);
    a_in = a; b_in = b; is_signed = s; flags_in = f; in_valid = 1'b1; out_ready = early;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk); t++;
    end
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a_in = $urandom; b_in = $urandom; is_signed = 1'($urandom); flags_in = 4'($urandom);
    wait_result(tag, eq, er, ef, ef[FlagV] ? 1 : 33);
  endtask

  initial begin
    logic [31:0] hq, hr, a, b, eq, er;
    logic [3:0]  hf, ef, f;
    logic        s;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset quot", quot, 32'd0);
    chk("reset rem", rem, 32'd0);
    chk("reset flags", 32'(flags_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases
    issue("u100/7", 32'd100, 32'd7, 1'b0, 4'b0000, 1'b0);
    issue("s-100/7", 32'hFFFF_FF9C, 32'd7, 1'b1, 4'b0010, 1'b0);
    issue("s5/0", 32'd5, 32'd0, 1'b1, 4'b0000, 1'b0);
    issue("u5/0", 32'd5, 32'd0, 1'b0, 4'b0000, 1'b1);
    issue("sMIN/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'b0000, 1'b0);
    issue("uMIN/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 4'b0000, 1'b0);
    issue("s100/-7 early", 32'd100, 32'hFFFF_FFF9, 1'b1, 4'b1111, 1'b1);

    // Backpressure with changing operands while the result is held
    @(negedge clk);
    a_in = 32'd1000; b_in = 32'd3; is_signed = 1'b0; flags_in = 4'b0000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    begin : bp_first
      int lat;
      lat = 0;
      while (!out_valid && lat < 100) begin
        @(posedge clk); #1; lat++;
      end
      chk("bp latency", 32'(lat), 32'd33);
    end
    ref_div(32'd1000, 32'd3, 1'b0, 4'b0000, eq, er, ef);
    chk("bp quot", quot, eq);
    chk("bp rem", rem, er);
    hq = quot; hr = rem; hf = flags_out;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a_in = $urandom; b_in = $urandom | 32'd1; is_signed = 1'($urandom);
      @(posedge clk); #1;
      chk("bp hold quot", quot, hq);
      chk("bp hold rem", rem, hr);
      chk("bp hold flags", 32'(flags_out), 32'(hf));
      chk("bp hold in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    a_in = 32'd77; b_in = 32'd5; is_signed = 1'b0; flags_in = 4'b0010; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp release valid", 32'(out_valid), 32'd0);
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp next accept", 32'(in_ready), 32'd0);
    ref_div(32'd77, 32'd5, 1'b0, 4'b0010, eq, er, ef);
    wait_result("bp next", eq, er, ef, 33);

    // Reset in the middle of iteration
    @(negedge clk);
    a_in = 32'd12345678; b_in = 32'd7; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst quot", quot, 32'd0);
    chk("midrst rem", rem, 32'd0);
    chk("midrst flags", 32'(flags_out), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    issue("u9/3", 32'd9, 32'd3, 1'b0, 4'b0000, 1'b0);

    // Randomized operands
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      s = 1'($urandom);
      f = 4'($urandom);
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom_range(1, 20);
        2: b = 32'(-$urandom_range(1, 20));
        3: b = 32'd0;
        default: begin a = 32'h8000_0000; b = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : $urandom; end
      endcase
      issue("rand", a, b, s, f, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
